// File: rtl/seq_det_pkg.sv
// Shared encodings for the serial 101 detector and its word controller.
// Optional statistics are enabled with SEQ_CTRL_STATS_EN.
package seq_det_pkg;

    localparam int DEF_WORD_W = 8;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        GOT_1   = 2'd1,
        GOT_10  = 2'd2,
        GOT_101 = 2'd3
    } core_st_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_st_t;

endpackage

// File: rtl/seq101_core.sv
// Overlapping "101" Mealy detector with synchronous clear and enable.
// History only advances when en is high; clr wins over en.
module seq101_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    core_st_t st;

    assign z = en & (st == GOT_10) & x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= RESET;
        end else if (clr) begin
            st <= RESET;
        end else if (en) begin
            case (st)
                RESET:   st <= x ? GOT_1   : RESET;
                GOT_1:   st <= x ? GOT_1   : GOT_10;
                GOT_10:  st <= x ? GOT_101 : RESET;
                GOT_101: st <= x ? GOT_1   : GOT_10;
                default: st <= RESET;
            endcase
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word controller: streams each word MSB-first through seq101_core.
// Define SEQ_CTRL_STATS_EN to add saturating stat_total/stat_words.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
`ifdef SEQ_CTRL_STATS_EN
    ,
    parameter int TOT_W = 16
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WORD_W-1:0]                 in_data,
    input  logic                              in_keep,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(WORD_W+1)-1:0]       out_count,
    output logic [$clog2(WORD_W+1)-1:0]       out_first
`ifdef SEQ_CTRL_STATS_EN
    ,
    output logic [TOT_W-1:0]                  stat_total,
    output logic [TOT_W-1:0]                  stat_words
`endif
);

    localparam int CNT_W = $clog2(WORD_W+1);

    ctrl_st_t          state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  first;
    logic              core_clr;
    logic              core_en;
    logic              core_z;

    assign in_ready  = (state == IDLE);
    assign out_count = match_cnt;
    assign out_first = first;

    // clr must act on the accept edge itself so the first bit is not lost
    assign core_clr = (state == IDLE) & in_valid & ~in_keep;
    assign core_en  = (state == SHIFT);

    seq101_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (core_clr),
        .en  (core_en),
        .x   (shreg[WORD_W-1]),
        .z   (core_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            match_cnt <= '0;
            first     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        bit_idx   <= '0;
                        match_cnt <= '0;
                        first     <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (core_z) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (match_cnt == '0)
                            first <= bit_idx;
                    end
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == CNT_W'(WORD_W-1))
                        state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_CTRL_STATS_EN
    logic             res_hs;
    logic [TOT_W:0]   tot_sum;
    logic [TOT_W:0]   wrd_sum;

    assign res_hs  = (state == DONE) & out_valid & out_ready;
    assign tot_sum = {1'b0, stat_total} + (TOT_W+1)'(match_cnt);
    assign wrd_sum = {1'b0, stat_words} + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_total <= '0;
            stat_words <= '0;
        end else if (res_hs) begin
            stat_total <= tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
            stat_words <= wrd_sum[TOT_W] ? '1 : wrd_sum[TOT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (8-bit words).
// With SEQ_CTRL_STATS_EN the stats run 4 bits wide to reach saturation.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_keep = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_count;
    logic [3:0] out_first;
`ifdef SEQ_CTRL_STATS_EN
    logic [3:0] stat_total;
    logic [3:0] stat_words;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .WORD_W(8)
`ifdef SEQ_CTRL_STATS_EN
        , .TOT_W(4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_first (out_first)
`ifdef SEQ_CTRL_STATS_EN
        , .stat_total(stat_total)
        , .stat_words(stat_words)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic put_word(input logic [7:0] d, input logic keep);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_tmo", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = keep;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) chk("valid_tmo", 0, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_word(input logic [7:0] d, input logic keep,
                            output int c, output int f);
        int lat;
        put_word(d, keep);
        wait_res(lat);
        c = int'(out_count);
        f = int'(out_first);
        ack();
    endtask

    initial begin
        int c, f, lat, seen;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_first", int'(out_first), 0);
        rst = 1'b1;

        put_word(8'hAA, 1'b0);
        wait_res(lat);
        chk("aa_latency", lat, 9);
        chk("aa_count", int'(out_count), 3);
        chk("aa_first", int'(out_first), 2);
        chk("aa_in_ready", int'(in_ready), 0);
        ack();
        chk("aa_ack_valid", int'(out_valid), 0);
        chk("aa_ack_ready", int'(in_ready), 1);

        run_word(8'h02, 1'b0, c, f);
        chk("w02_count", c, 0);
        run_word(8'h80, 1'b1, c, f);
        chk("keep_count", c, 1);
        chk("keep_first", f, 0);
        run_word(8'h02, 1'b0, c, f);
        run_word(8'h80, 1'b0, c, f);
        chk("nokeep_count", c, 0);
        chk("nokeep_first", f, 0);

        run_word(8'hFF, 1'b0, c, f);
        chk("ff_count", c, 0);
        chk("ff_first", f, 0);
        run_word(8'h00, 1'b0, c, f);
        chk("00_count", c, 0);
        chk("00_first", f, 0);
        run_word(8'h15, 1'b0, c, f);
        chk("15_count", c, 2);
        chk("15_first", f, 5);

        put_word(8'hAA, 1'b0);
        wait_res(lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h15;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_count", int'(out_count), 3);
            chk("hold_first", int'(out_first), 2);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold_ack_valid", int'(out_valid), 0);
        chk("hold_ack_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("hold_not_taken", int'(in_ready), 1);

        put_word(8'hAA, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_count", int'(out_count), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", int'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_stale", seen, 0);
        chk("idle_ready", int'(in_ready), 1);

`ifdef SEQ_CTRL_STATS_EN
        chk("st_rst_total", int'(stat_total), 0);
        chk("st_rst_words", int'(stat_words), 0);
        run_word(8'hAA, 1'b0, c, f);
        run_word(8'hAA, 1'b0, c, f);
        chk("st_total2", int'(stat_total), 6);
        chk("st_words2", int'(stat_words), 2);
        repeat (3) run_word(8'hAA, 1'b0, c, f);
        chk("st_total15", int'(stat_total), 15);
        run_word(8'hAA, 1'b0, c, f);
        chk("st_total_sat", int'(stat_total), 15);
        chk("st_words6", int'(stat_words), 6);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
